// File: rtl/arbitro_contador_n_if.sv
// Request/grant bundle between the timing clients and the shared modulo-N counter.
// The master side belongs to the requesters; the slave side belongs to the arbiter/counter.
interface arbitro_contador_n_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] n_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      q;
  logic              busy;

  modport master (output req, output n_in, input gnt, input done, input q, input busy);
  modport slave  (input req, input n_in, output gnt, output done, output q, output busy);
endinterface

// File: rtl/arbitro_contador_n.sv
// Shared 0..N counter granted to one requester at a time, with a one-cycle done pulse per job.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module arbitro_contador_n #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  arbitro_contador_n_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_nlat;
  logic [IW-1:0]   r_owner;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_done_nxt;
  logic [W-1:0]    w_q_nxt;
  logic [W-1:0]    w_nlat_nxt;
  logic [IW-1:0]   w_owner_nxt;
  logic [IW-1:0]   w_start;
  logic [IW-1:0]   w_win;
  logic            w_any;

  // First requesting index found when scanning upward from start, wrapping at NREQ.
  function automatic logic [IW-1:0] f_pick(input logic [NREQ-1:0] req_v, input logic [IW-1:0] start);
    logic [IW-1:0] win;
    logic [IW-1:0] idx_w;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = int'(start) + k;
      idx   = (idx >= NREQ) ? (idx - NREQ) : idx;
      idx_w = IW'(idx);
      if (!found && req_v[idx_w]) begin
        win   = idx_w;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  function automatic logic [W-1:0] f_slice(input logic [NREQ*W-1:0] n_v, input logic [IW-1:0] sel);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == sel) begin
        r = n_v[i*W +: W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;

  assign w_start   = r_ptr;
  assign w_ptr_nxt = (w_any && (r_state == ST_IDLE))
                     ? ((w_win == IW'(NREQ - 1)) ? '0 : (w_win + IW'(1)))
                     : r_ptr;

  // Round-robin pointer: advances past every granted index, aborted jobs included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  assign w_start = '0;
`endif

  assign w_any = |bus.req;
  assign w_win = f_pick(bus.req, w_start);

  // Next-state and next-output decode for the IDLE/COUNT/DONE job sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_q_nxt     = r_q;
    w_nlat_nxt  = r_nlat;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        w_q_nxt   = '0;
        if (w_any) begin
          w_state_nxt = ST_COUNT;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_nlat_nxt  = f_slice(bus.n_in, w_win);
          w_owner_nxt = w_win;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_q_nxt     = '0;
        end else if (r_q == r_nlat) begin
          w_state_nxt = ST_DONE;
          w_gnt_nxt   = '0;
          w_q_nxt     = '0;
          w_done_nxt  = NREQ'(1) << r_owner;
        end else begin
          w_q_nxt = r_q + W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_q_nxt     = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_q_nxt     = '0;
      end
    endcase
  end

  // State and output registers; busy is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_q     <= '0;
      r_nlat  <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_q     <= w_q_nxt;
      r_nlat  <= w_nlat_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.q    = r_q;
  assign bus.busy = r_busy;

endmodule
